fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the toy pipelined CPU. It produces the instruction stream that the ID-stage control decoder consumes, and it consumes the decoder's redirect (`sigPC`) and halt (`sigH`) outputs. The block owns the PC, drives the instruction-memory read handshake, and holds a one-entry skid buffer so that no fetched word is lost during a stall. It inserts NOP bubbles (`inst = 0`) whenever memory is slow or a redirect squashes the wrong-path word.

## Interface
Parameters:
- `WORD_SIZE`, 16: instruction, address and data width.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; everything is updated on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  ID stage is held by the hazard unit; `inst`, `inst_pc` and `inst_valid` must hold.
- `sigPC`  in  2  redirect request from control: 00 = +1, 01 = taken branch, 10 = jump, 11 = register jump.
- `sigH`  in  1  HLT is decoded in ID.
- `rs_data`  in  WORD_SIZE  forwarded $rs value, used as the target for JPR/JRL.
- `i_readM`  out  1  instruction memory read request.
- `i_address`  out  WORD_SIZE  fetch address.
- `i_data`  in  WORD_SIZE  memory read data; valid when `i_inputReady` = 1.
- `i_inputReady`  in  1  memory response for the current request.
- `inst`  out  WORD_SIZE  instruction presented to ID; 0 means NOP/bubble.
- `inst_pc`  out  WORD_SIZE  PC of `inst`. Used by JAL/JRL and for branch targets.
- `inst_valid`  out  1  `inst` is a real fetched word and not a bubble.

## Operation
- State machine states: IDLE (one cycle after reset), REQ (request outstanding), FULL (skid buffer occupied), HALT.
- Priority at each edge: reset > `sigH` > redirect > `stall` > normal.
- Internal registers: `fetch_pc`, `buf_inst`, `buf_pc`.
- Output decode:
  - `i_readM` = 1 only in REQ.
  - `i_address` = `fetch_pc` in every state.
- Redirect target, used only when `stall` = 0 and `sigPC` ≠ 00. All arithmetic is mod 2^16 with no overflow flag.
  - Branch (01): `inst_pc + 1 + sext(inst[7:0])`.
  - Jump (10): `{inst_pc[15:12], inst[11:0]}`.
  - Register jump (11): `rs_data`.
- Redirect action:
  - `fetch_pc` ← target.
  - `inst` ← 0 and `inst_valid` ← 0, which squashes the wrong-path word.
  - `buf_inst` is discarded.
  - State ← REQ.
  - Any response arriving on the same edge is dropped.
  - If `i_readM` stays high and the address changes, memory restarts the access.
- Redirect while `stall` = 1 is ignored. Control already zeroes `sigPC` under stall.
- REQ, `i_inputReady` = 1, `stall` = 0:
  - `inst` ← `i_data`, `inst_pc` ← `fetch_pc`, `inst_valid` ← 1.
  - `fetch_pc` ← `fetch_pc` + 1; stay in REQ.
- REQ, `i_inputReady` = 1, `stall` = 1:
  - `buf_inst` ← `i_data`, `buf_pc` ← `fetch_pc`, `fetch_pc` += 1.
  - State ← FULL. ID outputs hold.
- REQ, `i_inputReady` = 0: if `stall` = 0, insert a bubble (`inst` ← 0, `inst_valid` ← 0); otherwise hold.
- FULL: when `stall` = 0, move the buffer into `inst`/`inst_pc`, set `inst_valid` = 1, state ← REQ.
- `sigH` = 1 with `stall` = 0:
  - State ← HALT, `inst` ← 0, `inst_valid` ← 0.
  - No further requests; HALT is left only by reset.
- Wrap-around: `fetch_pc` = 16'hFFFF increments to 16'h0000.

## Timing
- Reset values:
  - `i_readM` = 0, `i_address` = RESET_PC.
  - `inst` = 0, `inst_pc` = 0, `inst_valid` = 0.
  - `fetch_pc` = RESET_PC, buffer empty, state IDLE.
- Reset asserted in any state, mid-request included: the next edge restores every reset value. Any in-flight response is ignored.
- IDLE → REQ on the first edge after `reset` falls, so `i_readM` rises one cycle after reset deasserts.
- Latency: `i_inputReady` seen on edge N gives `inst` valid in cycle N+1. With a zero-wait memory the throughput is one instruction per cycle.
- `i_address` is stable while `i_readM` = 1 unless a redirect occurs.
- Redirect bubble cost: 1 cycle plus the memory latency of the target fetch.

## Structure
- `parameter.v` holds `WORD_SIZE`, `RESET_PC` and the `sigPC` encodings (`PC_NEXT`, `PC_BR`, `PC_JMP`, `PC_JR`) shared with control.
- State encodings are local parameters.
- One combinational sub-module, `fetch_target`: it takes `sigPC`, `inst`, `inst_pc` and `rs_data` and outputs the 16-bit next-PC target. It is reusable by the ID stage.

## Test plan
- Reset, then a zero-wait memory → `i_address` 0,1,2,3 on consecutive cycles; `inst_pc` 0,1,2 one cycle later; `inst_valid` = 1 continuously.
- Memory with 2 wait cycles → exactly 2 bubbles (`inst` = 0, `inst_valid` = 0) between instructions; no duplicated `inst_pc`.
- `stall` = 1 asserted while a request is outstanding and the response arrives → state FULL, `i_readM` = 0, ID outputs held. After `stall` drops, the buffered word appears with the correct PC and the next fetch is PC+1.
- BEQ at 0x0005 with imm 0xFE and `sigPC` = 01 → the following `inst` = 0 and the next `i_address` = 0x0004.
- JMP at 0x1003 with `inst[11:0]` = 0x020 → next `i_address` = 0x1020. Then `sigPC` = 11, `rs_data` = 0x1234 together with `stall` = 1 → ignored; applied on the first cycle with `stall` = 0.
- `sigH` = 1 → `i_readM` stays 0 indefinitely. Asserting `reset` mid-request returns the block to fetching from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage and its users.
package fetch_unit_pkg;

    localparam int          FU_WORD_SIZE = 16;
    localparam logic [15:0] FU_RESET_PC  = 16'h0000;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_JR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_FULL = 2'b10,
        ST_HALT = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_target.sv
// Next-PC target calculation for redirects; purely combinational so ID can reuse it.
module fetch_target
    import fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = FU_WORD_SIZE
) (
    input  logic [1:0]           sig_pc_i,
    input  logic [11:0]          inst_i,
    input  logic [WORD_SIZE-1:0] inst_pc_i,
    input  logic [WORD_SIZE-1:0] rs_data_i,
    output logic [WORD_SIZE-1:0] target_o
);

    logic [WORD_SIZE-1:0] br_offset_s;

    // Target select; all sums wrap modulo 2^WORD_SIZE.
    always_comb begin
        br_offset_s = {{(WORD_SIZE-8){inst_i[7]}}, inst_i[7:0]};
        case (sig_pc_i)
            PC_BR:   target_o = inst_pc_i + WORD_SIZE'(1) + br_offset_s;
            PC_JMP:  target_o = {inst_pc_i[WORD_SIZE-1:12], inst_i[11:0]};
            PC_JR:   target_o = rs_data_i;
            PC_NEXT: target_o = inst_pc_i + WORD_SIZE'(1);
            default: target_o = inst_pc_i + WORD_SIZE'(1);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem handshake and keeps a
// one-entry skid buffer so a response landing during a stall is not lost.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = FU_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = FU_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [1:0]           sigPC,
    input  logic                 sigH,
    input  logic [WORD_SIZE-1:0] rs_data,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_inputReady,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic                 inst_valid
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] buf_inst_q, buf_inst_d;
    logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [WORD_SIZE-1:0] inst_pc_q, inst_pc_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [WORD_SIZE-1:0] target_s;
    logic                 redirect_s;

    fetch_target #(.WORD_SIZE(WORD_SIZE)) u_target (
        .sig_pc_i  (sigPC),
        .inst_i    (inst_q[11:0]),
        .inst_pc_i (inst_pc_q),
        .rs_data_i (rs_data),
        .target_o  (target_s)
    );

    assign redirect_s = (sigPC != PC_NEXT) && !stall;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_pc_q     <= buf_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state: halt beats redirect beats stall; redirect drops any same-edge response.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ, ST_FULL: begin
                if (sigH && !stall) begin
                    state_d      = ST_HALT;
                    inst_d       = '0;
                    inst_valid_d = 1'b0;
                end else if (redirect_s) begin
                    state_d      = ST_REQ;
                    fetch_pc_d   = target_s;
                    buf_inst_d   = '0;
                    inst_d       = '0;
                    inst_valid_d = 1'b0;
                end else if (state_q == ST_REQ) begin
                    if (i_inputReady && !stall) begin
                        inst_d       = i_data;
                        inst_pc_d    = fetch_pc_q;
                        inst_valid_d = 1'b1;
                        fetch_pc_d   = fetch_pc_q + WORD_SIZE'(1);
                    end else if (i_inputReady) begin
                        buf_inst_d = i_data;
                        buf_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + WORD_SIZE'(1);
                        state_d    = ST_FULL;
                    end else if (!stall) begin
                        inst_d       = '0;
                        inst_valid_d = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    if (!stall) begin
                        inst_d       = buf_inst_q;
                        inst_pc_d    = buf_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = ST_REQ;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign i_readM    = (state_q == ST_REQ);
    assign i_address  = fetch_pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule
